// File: rtl/fmap_stream_tx_pkg.sv
// Shared definitions for the feature-map stream transmitter: default data width,
// address-width helpers and the transmitter FSM state type.
package fmap_stream_tx_pkg;

  localparam int unsigned NnDataWidth = 16;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (clog2(depth) > 0) ? clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StGap,
    StDrain
  } tx_state_e;

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port frame memory: synchronous write, registered read with one
// cycle of latency. No reset on the array or the read register so it maps to block RAM.
module fmap_ram #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 36,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_din,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_din;
    end
    if (rd_en) begin
      rd_dout <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fmap_stream_tx.sv
// Frame-buffered feature-map transmitter. A frame is loaded through a random-access
// write port while idle; on start it is replayed in raster order, one packed pixel
// per ce-cycle, with optional idle gaps between rows.
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int unsigned N        = NnDataWidth,
  parameter int unsigned CHANNEL  = 3,
  parameter int unsigned SIZE     = 6,
  parameter int unsigned LINE_GAP = 0,
  localparam int unsigned DEPTH   = SIZE * SIZE,
  localparam int unsigned AW      = addr_width(DEPTH),
  localparam int unsigned W       = CHANNEL * N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_din,
  output logic          wr_err,
  input  logic          start,
  output logic          busy,
  output logic [W-1:0]  stream_dout,
  output logic          stream_dout_vld,
  output logic          stream_dout_end
);

  localparam int unsigned CW = addr_width(SIZE);
  localparam logic [CW-1:0] ColLast  = CW'(SIZE - 1);
  localparam logic [CW-1:0] RowLast  = CW'(SIZE - 1);
  localparam logic [3:0]    GapLast  = 4'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [AW:0]   DepthLim = (AW + 1)'(DEPTH);

  tx_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    gap_q, gap_d;
  logic          vld_q, end_q, wr_err_q;
  // Set once the RAM read register holds a real pixel; masks it to 0 after reset.
  logic          shown_q;
  logic          issue, last_px;
  logic          wr_ok, wr_commit;
  logic [W-1:0]  ram_dout;

  assign wr_ok     = (state_q == StIdle) && ({1'b0, wr_addr} < DepthLim);
  assign wr_commit = wr_en & ce & wr_ok;

  fmap_ram #(
    .WIDTH(W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_commit),
    .wr_addr(wr_addr),
    .wr_din (wr_din),
    .rd_en  (ce & issue),
    .rd_addr(addr_q),
    .rd_dout(ram_dout)
  );

  // Next-state logic: sequences the raster read, inserting row gaps.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    last_px = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      StRead: begin
        issue  = 1'b1;
        addr_d = addr_q + AW'(1);
        if (col_q == ColLast) begin
          col_d = '0;
          if (row_q == RowLast) begin
            last_px = 1'b1;
            state_d = StDrain;
          end else begin
            row_d = row_q + CW'(1);
            if (LINE_GAP > 0) begin
              state_d = StGap;
              gap_d   = '0;
            end
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StRead;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and output flags; everything holds while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      gap_q    <= '0;
      vld_q    <= 1'b0;
      end_q    <= 1'b0;
      shown_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      gap_q    <= gap_d;
      vld_q    <= issue;
      end_q    <= last_px;
      shown_q  <= shown_q | issue;
      wr_err_q <= wr_en & ~wr_ok;
    end
  end

  assign busy            = (state_q != StIdle);
  assign stream_dout     = shown_q ? ram_dout : '0;
  assign stream_dout_vld = vld_q;
  assign stream_dout_end = end_q;
  assign wr_err          = wr_err_q;

endmodule
